// File: rtl/spi_sched_pkg.sv
// Shared types and defaults for the button-to-SPI scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_sched_pkg;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int          DEF_DATA_W         = 8;
    localparam int          DEF_GAP_CYCLES     = 16;
    localparam logic [19:0] DEF_TIMEOUT_CYCLES = 20'd1000000;

endpackage

// File: rtl/btn_spi_sched_rr_arbiter.sv
// Round-robin arbiter: picks the first set request after the pointer, wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides whether the grant is consumed.
// Ports: req (request vector), ptr (last granted ID),
//        grant_oh (one-hot grant), grant_id (binary grant), any_grant (req != 0).
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant_oh,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_grant
);

    logic [ID_W-1:0] idx;

    // Walk ptr+1, ptr+2, ... ptr+NUM_REQ so the last winner has lowest priority.
    always_comb begin
        grant_oh  = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        idx       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            idx = ID_W'((int'(ptr) + off) % NUM_REQ);
            if (!any_grant && req[idx]) begin
                any_grant     = 1'b1;
                grant_id      = idx;
                grant_oh[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/btn_spi_sched.sv
// Shares one SPI master among NUM_REQ button requesters, one byte per press, round-robin.
// Latency: press->spi_start 3 edges; spi_done->rsp_valid 2 edges; GAP_CYCLES idle clocks between transactions.
// Backpressure: one queued press per requester (extra presses pulse overflow); WAIT holds until spi_done.
// Ports: clock/reset (async active-high); req_pulse/req_data from debouncers;
//        spi_start/spi_tx_data/spi_done/spi_rx_data to the SPI master;
//        rsp_valid/rsp_id/rsp_data response; pending, overflow, timeout status.
// Optional: define SPI_SCHED_TIMEOUT_EN to abort WAIT after TIMEOUT_CYCLES clocks.
module btn_spi_sched
    import spi_sched_pkg::*;
#(
    parameter int          NUM_REQ        = 4,
    parameter int          DATA_W         = DEF_DATA_W,
    parameter int          GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter logic [19:0] TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int          ID_W           = $clog2(NUM_REQ)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_pulse,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      spi_start,
    output logic [DATA_W-1:0]         spi_tx_data,
    input  logic                      spi_done,
    input  logic [DATA_W-1:0]         spi_rx_data,
    output logic                      rsp_valid,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [NUM_REQ-1:0]        pending,
    output logic                      overflow,
    output logic                      timeout
);

    localparam int GAP_W = $clog2(GAP_CYCLES) + 1;

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q;          // last granted ID, also the in-flight requester
    logic [NUM_REQ-1:0]  arb_oh;
    logic [ID_W-1:0]     arb_id;
    logic                arb_any;
    logic                grant;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic                gap_done;
    logic                done_ok;        // spi_done accepted (only meaningful in WAIT)
    logic                to_hit;
    logic                rsp_pend_q;     // response captured, strobe rsp_valid next edge
    logic                spi_start_d;
    logic                rsp_pend_d;
    logic [NUM_REQ-1:0]  clr_mask;
    logic [NUM_REQ-1:0]  pending_d;
    logic                overflow_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req       (pending),
        .ptr       (ptr_q),
        .grant_oh  (arb_oh),
        .grant_id  (arb_id),
        .any_grant (arb_any)
    );

    assign grant    = (state_q == IDLE) && arb_any;
    assign done_ok  = (state_q == WAIT) && spi_done;
    assign gap_done = (state_q == GAP) && (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));

    // A press landing on the grant edge re-arms the bit (set beats clear) and is
    // not an overflow, since the old entry is leaving the queue on that edge.
    assign clr_mask   = grant ? arb_oh : '0;
    assign pending_d  = (pending & ~clr_mask) | req_pulse;
    assign overflow_d = |(req_pulse & pending & ~clr_mask);

`ifdef SPI_SCHED_TIMEOUT_EN
    logic [19:0] to_cnt_q;
    logic        timeout_q;

    // spi_done on the final WAIT clock still completes normally.
    assign to_hit  = (state_q == WAIT) && !spi_done && (to_cnt_q == TIMEOUT_CYCLES - 20'd1);
    assign timeout = timeout_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            to_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= (state_q == WAIT) ? to_cnt_q + 20'd1 : 20'd0;
            timeout_q <= to_hit;
        end
    end
`else
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_any) state_d = START;
            START:   state_d = WAIT;
            WAIT:    if (spi_done || to_hit) state_d = GAP;
            GAP:     if (gap_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs, registered below so every port is a flop.
    always_comb begin
        spi_start_d = (state_q == START);
        rsp_pend_d  = done_ok;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spi_start   <= 1'b0;
            spi_tx_data <= '0;
            rsp_pend_q  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            pending     <= '0;
            overflow    <= 1'b0;
            ptr_q       <= '0;
            gap_cnt_q   <= '0;
        end else begin
            spi_start  <= spi_start_d;
            rsp_pend_q <= rsp_pend_d;
            rsp_valid  <= rsp_pend_q;
            pending    <= pending_d;
            overflow   <= overflow_d;
            // Command byte is captured once at grant and held through WAIT.
            if (grant) begin
                ptr_q       <= arb_id;
                spi_tx_data <= req_data[int'(arb_id)*DATA_W +: DATA_W];
            end
            if (done_ok) begin
                rsp_id   <= ptr_q;
                rsp_data <= spi_rx_data;
            end
            gap_cnt_q <= (state_q == GAP) ? gap_cnt_q + GAP_W'(1) : '0;
        end
    end

endmodule

// File: tb/tb_btn_spi_sched.sv
// Self-checking bench for btn_spi_sched: directed presses, scoreboard queues, negedge monitor.
// Latency: n/a.
// Backpressure: a behavioural SPI responder answers each spi_start after a fixed delay.
module tb_btn_spi_sched;

    localparam int GAP = 4;
    localparam int TO  = 50;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] dat;
    } rsp_t;

    logic        clock;
    logic        reset;
    logic [3:0]  req_pulse;
    logic [31:0] req_data;
    logic        spi_start;
    logic [7:0]  spi_tx_data;
    logic        spi_done;
    logic [7:0]  spi_rx_data;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
    logic [3:0]  pending;
    logic        overflow;
    logic        timeout;

    btn_spi_sched #(
        .NUM_REQ        (4),
        .DATA_W         (8),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (20'd50)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_pulse   (req_pulse),
        .req_data    (req_data),
        .spi_start   (spi_start),
        .spi_tx_data (spi_tx_data),
        .spi_done    (spi_done),
        .spi_rx_data (spi_rx_data),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .pending     (pending),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    logic [7:0] exp_tx[$];
    rsp_t       exp_rsp[$];

    int n_checks   = 0;
    int n_errors   = 0;
    int cyc        = 0;
    int n_start    = 0;
    int n_rsp      = 0;
    int n_ovf      = 0;
    int n_to       = 0;
    int start_idx  = 0;
    int done_idx   = 0;
    bit have_done  = 0;
    bit prev_start = 0;
    bit resp_en    = 1;
    int stray_req  = 0;
    int stray_ack  = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach its end, errors so far %0d", n_errors);
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
        end
    endtask

    task automatic chk_min(input string name, input int act, input int lo);
        n_checks++;
        if (act < lo) begin
            n_errors++;
            $display("FAIL %s: got %0d, want at least %0d", name, act, lo);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_spi_start"},   spi_start,   0);
        chk({tag, "_spi_tx_data"}, spi_tx_data, 0);
        chk({tag, "_rsp_valid"},   rsp_valid,   0);
        chk({tag, "_rsp_id"},      rsp_id,      0);
        chk({tag, "_rsp_data"},    rsp_data,    0);
        chk({tag, "_pending"},     pending,     0);
        chk({tag, "_overflow"},    overflow,    0);
        chk({tag, "_timeout"},     timeout,     0);
    endtask

    // Called on a negedge; returns on the negedge after the pulse was sampled.
    task automatic press(input logic [3:0] m);
        req_pulse = m;
        @(negedge clock);
        req_pulse = 4'b0000;
    endtask

    task automatic wait_starts(input int target);
        int t = 0;
        while (n_start < target && t < 500) begin
            @(negedge clock);
            t++;
        end
        chk("start_seen", n_start >= target, 1);
    endtask

    task automatic wait_quiet();
        int t = 0;
        while ((exp_tx.size() != 0 || exp_rsp.size() != 0) && t < 2000) begin
            @(negedge clock);
            t++;
        end
        chk("scoreboard_drained", t < 2000, 1);
        repeat (GAP + 6) @(negedge clock);
    endtask

    function automatic rsp_t mk(input logic [1:0] id, input logic [7:0] dat);
        rsp_t r;
        r.id  = id;
        r.dat = dat;
        return r;
    endfunction

    // SPI master model: answers each launch after 6 clocks with tx ^ 8'h99.
    initial begin
        int         cd = 0;
        logic [7:0] rx_hold = 8'h00;
        spi_done    = 1'b0;
        spi_rx_data = 8'h00;
        forever begin
            @(negedge clock);
            spi_done = 1'b0;
            if (reset) begin
                cd = 0;
            end else if (cd != 0) begin
                cd--;
                if (cd == 0) begin
                    spi_done    = 1'b1;
                    spi_rx_data = rx_hold;
                end
            end else if (stray_req != stray_ack) begin
                stray_ack++;
                spi_done    = 1'b1;
                spi_rx_data = 8'hEE;
            end
            if (!reset && spi_start && resp_en) begin
                cd      = 6;
                rx_hold = spi_tx_data ^ 8'h99;
            end
        end
    end

    // Index of the negedge that follows the edge on which spi_done was sampled.
    initial begin
        forever begin
            @(posedge clock);
            if (!reset && spi_done) begin
                done_idx  = cyc + 1;
                have_done = 1;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an output.
    initial begin
        logic [7:0] e;
        rsp_t       r;
        forever begin
            @(negedge clock);
            cyc++;
            if (reset) begin
                prev_start = 0;
            end else begin
                if (spi_start) begin
                    chk("start_one_cycle", prev_start, 0);
                    n_start++;
                    start_idx = cyc;
                    chk("start_expected", exp_tx.size() != 0, 1);
                    if (exp_tx.size() != 0) begin
                        e = exp_tx.pop_front();
                        chk("start_tx_data", spi_tx_data, e);
                    end
                    if (have_done) chk_min("gap_after_done", cyc - done_idx, GAP + 2);
                end
                if (rsp_valid) begin
                    n_rsp++;
                    chk("rsp_latency", cyc - done_idx, 1);
                    chk("rsp_expected", exp_rsp.size() != 0, 1);
                    if (exp_rsp.size() != 0) begin
                        r = exp_rsp.pop_front();
                        chk("rsp_id", rsp_id, r.id);
                        chk("rsp_data", rsp_data, r.dat);
                    end
                end
                if (overflow) n_ovf++;
                if (timeout) begin
                    n_to++;
                    chk("timeout_latency", cyc - start_idx, TO);
                end
                prev_start = spi_start;
            end
        end
    end

    initial begin
        int lat;
        int base_st;
        int base_ovf;
        int base_rsp;
        int base_to;
        int t;
        reset     = 1'b1;
        req_pulse = 4'b0000;
        req_data  = 32'h0;
        repeat (3) @(negedge clock);
        chk_zero("reset");
        reset = 1'b0;
        @(negedge clock);

        // Single press on requester 2.
        req_data = {8'h43, 8'hA5, 8'h21, 8'h10};
        exp_tx.push_back(8'hA5);
        exp_rsp.push_back(mk(2'd2, 8'h3C));
        press(4'b0100);
        chk("pending_after_press", pending, 4'b0100);
        lat = 1;
        while (!spi_start && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        chk("press_to_start", lat, 3);
        wait_quiet();

        // Requester 3 alone, leaves the pointer at 3.
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        exp_tx.push_back(8'h43);
        exp_rsp.push_back(mk(2'd3, 8'hDA));
        press(4'b1000);
        wait_quiet();

        // Round-robin: 0,1,3 together; re-press 0 and 3 while 1 is in flight.
        base_st  = n_start;
        base_ovf = n_ovf;
        exp_tx.push_back(8'h10); exp_tx.push_back(8'h21);
        exp_tx.push_back(8'h43); exp_tx.push_back(8'h10);
        exp_rsp.push_back(mk(2'd0, 8'h89)); exp_rsp.push_back(mk(2'd1, 8'hB8));
        exp_rsp.push_back(mk(2'd3, 8'hDA)); exp_rsp.push_back(mk(2'd0, 8'h89));
        press(4'b1011);
        chk("rr_pending", pending, 4'b1011);
        wait_starts(base_st + 2);
        press(4'b1001);
        chk("rr_overflow_on_3", overflow, 1);
        wait_quiet();
        chk("rr_overflow_count", n_ovf - base_ovf, 1);
        chk("rr_start_count", n_start - base_st, 4);

        // Overflow: requester 1 pressed twice while busy on 0.
        base_st  = n_start;
        base_ovf = n_ovf;
        exp_tx.push_back(8'h10); exp_tx.push_back(8'h21);
        exp_rsp.push_back(mk(2'd0, 8'h89)); exp_rsp.push_back(mk(2'd1, 8'hB8));
        press(4'b0001);
        wait_starts(base_st + 1);
        press(4'b0010);
        chk("ovf_first_press", overflow, 0);
        press(4'b0010);
        chk("ovf_second_press", overflow, 1);
        chk("ovf_pending", pending, 4'b0010);
        wait_quiet();
        chk("ovf_count", n_ovf - base_ovf, 1);
        chk("ovf_one_txn", n_start - base_st, 2);

        // spi_done while idle must be ignored.
        base_rsp = n_rsp;
        base_st  = n_start;
        stray_req++;
        repeat (GAP + 8) @(negedge clock);
        chk("stray_done_no_rsp", n_rsp - base_rsp, 0);
        chk("stray_done_no_start", n_start - base_st, 0);

`ifdef SPI_SCHED_TIMEOUT_EN
        // Requester 2 times out (pointer at 1), requester 3 then runs normally.
        resp_en = 0;
        base_to = n_to;
        exp_tx.push_back(8'h32); exp_tx.push_back(8'h43);
        exp_rsp.push_back(mk(2'd3, 8'hDA));
        press(4'b1100);
        t = 0;
        while (n_to == base_to && t < 300) begin
            @(negedge clock);
            t++;
        end
        chk("timeout_seen", n_to - base_to, 1);
        resp_en = 1;
        wait_quiet();
        chk("timeout_pending_clear", pending, 4'b0000);
`else
        base_to = n_to;
        t = 0;
`endif

        // Asynchronous reset in the middle of WAIT.
        resp_en = 0;
        base_rsp = n_rsp;
        base_st  = n_start;
        exp_tx.push_back(8'h21);
        press(4'b0010);
        wait_starts(base_st + 1);
        press(4'b1000);
        repeat (2) @(negedge clock);
        chk("pending_before_reset", pending, 4'b1000);
        chk("tx_before_reset", spi_tx_data, 8'h21);
        #2 reset = 1'b1;
        #1 chk_zero("reset_mid_wait");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (GAP + 4) @(negedge clock);
        chk("no_rsp_after_abort", n_rsp - base_rsp, 0);

        // After reset the pointer is 0, so 1 beats 3.
        resp_en = 1;
        exp_tx.push_back(8'h21); exp_tx.push_back(8'h43);
        exp_rsp.push_back(mk(2'd1, 8'hB8)); exp_rsp.push_back(mk(2'd3, 8'hDA));
        press(4'b1010);
        wait_quiet();

        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
`ifndef SPI_SCHED_TIMEOUT_EN
        chk("timeout_never", n_to, 0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/btn_spi_sched.md
# btn_spi_sched

Round-robin scheduler that shares one SPI master between NUM_REQ debounced button requesters. Each single-cycle press pulse from a debouncer queues a one-byte SPI transaction carrying that requester's command byte. The scheduler launches transactions one at a time, returns the received byte tagged with the requester ID, and enforces an inter-transaction gap. It sits between the debouncer bank and the SPI master.

## Interface
- NUM_REQ, 4: number of requesters (2..8)
- DATA_W, 8: SPI word width
- GAP_CYCLES, 16: idle clocks between transactions (≥1)
- TIMEOUT_CYCLES, 20'd1000000: max clocks in WAIT before abort (20-bit)
- ID_W, $clog2(NUM_REQ): requester ID width
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- req_pulse  in  NUM_REQ  single-cycle press pulses, one bit per requester
- req_data  in  NUM_REQ*DATA_W  command byte per requester; slice i = [i*DATA_W +: DATA_W]
- spi_start  out  1  one-cycle launch strobe to SPI master
- spi_tx_data  out  DATA_W  byte to send; held stable from START until exit from WAIT
- spi_done  in  1  one-cycle completion strobe from SPI master
- spi_rx_data  in  DATA_W  received byte, valid while spi_done=1
- rsp_valid  out  1  one-cycle response strobe
- rsp_id  out  ID_W  requester ID of the response
- rsp_data  out  DATA_W  received byte
- pending  out  NUM_REQ  queued-request bits
- overflow  out  1  one-cycle pulse: a press arrived for an already-pending requester
- timeout  out  1  one-cycle pulse: transaction aborted (macro-gated)

## Operation
- Pending: on req_pulse[i], set pending[i]. If pending[i] is already 1, leave it set and pulse overflow; no second queue entry. Clear pending[i] on the edge where i is granted. If a grant and a new pulse for the same i occur together, the set wins, so the new press stays queued, with no overflow.
- Arbitration: round-robin. Pointer reset value is 0. Search starts at last_grant+1, modulo NUM_REQ. After a grant, the pointer equals the granted ID.
- FSM states and transitions:
  - IDLE: if pending≠0, latch grant ID and req_data slice into spi_tx_data, then go to START.
  - START: spi_start=1 for exactly this cycle, then go to WAIT.
  - WAIT: on spi_done, register rsp_data=spi_rx_data and rsp_id=grant, pulse rsp_valid the next cycle, and go to GAP.
  - GAP: count GAP_CYCLES clocks, then go to IDLE.
- A spi_done outside WAIT is ignored.
- req_data is sampled only in IDLE. Later changes do not affect an in-flight transaction.
- Reset mid-transaction aborts immediately: FSM goes to IDLE, pending is cleared, no rsp_valid is issued.
- Reset values: spi_start=0, spi_tx_data=0, rsp_valid=0, rsp_id=0, rsp_data=0, pending=0, overflow=0, timeout=0, pointer=0.

## Timing
- All outputs are registered.
- Press to launch: with req_pulse sampled high at edge n and the FSM in IDLE, pending is 1 after edge n and spi_start is high in the cycle after edge n+2.
- Completion to response: spi_done sampled at edge m gives rsp_valid high in the cycle after edge m+1.
- Back-to-back: the next spi_start comes no earlier than GAP_CYCLES+2 clocks after the spi_done sample.
- overflow rises in the cycle after the offending req_pulse edge.

## Configuration
- SPI_SCHED_TIMEOUT_EN defined:
  - A 20-bit counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES without spi_done: pulse timeout for 1 cycle, issue no rsp_valid, go to GAP.
  - The request is dropped, not re-queued.
- SPI_SCHED_TIMEOUT_EN undefined:
  - No counter; WAIT holds indefinitely.
  - timeout is tied to 0.

## Structure
- Shared package spi_sched_pkg holds:
  - the state enum (IDLE, START, WAIT, GAP);
  - default constants for DATA_W, GAP_CYCLES and TIMEOUT_CYCLES.
- One sub-module, rr_arbiter:
  - inputs: request vector, pointer;
  - outputs: grant one-hot, grant ID, any-grant flag;
  - purely combinational.
- The FSM, gap counter and timeout counter live in the top module.

## Test plan
- Single press: pulse bit 2 with req_data slice 2=8'hA5 → spi_start 2 clocks later with spi_tx_data=8'hA5. Then spi_done with rx=8'h3C → rsp_valid with rsp_id=2, rsp_data=8'h3C.
- Round-robin: pulse bits 0,1,3 in the same cycle → grant order 0,1,3. Re-pulse 0 and 3 during the transaction for 1 → next grants are 3, then 0.
- Overflow: pulse bit 1 twice while busy on 0 → one overflow pulse, exactly one transaction for 1.
- Gap: two queued requests → spi_start edges separated by ≥GAP_CYCLES+2 clocks. Out-of-WAIT spi_done is ignored (no rsp_valid).
- Timeout (SPI_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=50): withhold spi_done → timeout pulse after 50 WAIT clocks, no rsp_valid, next pending request launches after the gap.
- Reset mid-WAIT: assert reset asynchronously → all outputs 0 and pending=0 immediately. After release, a new press launches normally from pointer 0.
